// File: rtl/arm_ctrl_pkg.sv
// Shared micro-state numbers, encoder class codes and class helpers.
// Used by the sequencer, the encoder and the control-signal ROM.
package arm_ctrl_pkg;

  localparam logic [5:0] S_RESET      = 6'd0;
  localparam logic [5:0] S_FETCH_ADDR = 6'd1;
  localparam logic [5:0] S_FETCH_READ = 6'd2;
  localparam logic [5:0] S_FETCH_INC  = 6'd3;
  localparam logic [5:0] S_DECODE     = 6'd4;
  localparam logic [5:0] S_LOAD_WAIT  = 6'd48;
  localparam logic [5:0] S_STORE_WAIT = 6'd49;
  localparam logic [5:0] S_WRITEBACK  = 6'd50;
  localparam logic [5:0] S_ABORT      = 6'd62;
  localparam logic [5:0] S_UNDEF      = 6'd63;

  localparam logic [5:0] C_DP_REG       = 6'd5;
  localparam logic [5:0] C_DP_IMM       = 6'd6;
  localparam logic [5:0] C_DP_SHIFT     = 6'd7;
  localparam logic [5:0] C_STR_OFF_IMM  = 6'd12;
  localparam logic [5:0] C_STR_OFF_REG  = 6'd13;
  localparam logic [5:0] C_STR_PRE_IMM  = 6'd14;
  localparam logic [5:0] C_STR_PRE_REG  = 6'd15;
  localparam logic [5:0] C_STR_POST_IMM = 6'd16;
  localparam logic [5:0] C_STR_POST_REG = 6'd18;
  localparam logic [5:0] C_LDR_OFF_IMM  = 6'd20;
  localparam logic [5:0] C_LDR_OFF_REG  = 6'd21;
  localparam logic [5:0] C_LDR_PRE_IMM  = 6'd22;
  localparam logic [5:0] C_LDR_PRE_REG  = 6'd23;
  localparam logic [5:0] C_LDR_POST_IMM = 6'd24;
  localparam logic [5:0] C_LDR_POST_REG = 6'd26;
  localparam logic [5:0] C_STRH_OFF     = 6'd35;
  localparam logic [5:0] C_STRH_PRE     = 6'd36;
  localparam logic [5:0] C_STRH_POST    = 6'd37;
  localparam logic [5:0] C_LDRH_OFF     = 6'd39;
  localparam logic [5:0] C_LDRH_PRE     = 6'd40;
  localparam logic [5:0] C_LDRH_POST    = 6'd41;
  localparam logic [5:0] C_B            = 6'd43;
  localparam logic [5:0] C_BL           = 6'd44;

  function automatic logic is_dp(input logic [5:0] c);
    return (c == C_DP_REG) || (c == C_DP_IMM) ||
           (c == C_DP_SHIFT);
  endfunction

  function automatic logic is_branch(input logic [5:0] c);
    return (c == C_B) || (c == C_BL);
  endfunction

  function automatic logic is_load(input logic [5:0] c);
    case (c)
      C_LDR_OFF_IMM, C_LDR_OFF_REG,
      C_LDR_PRE_IMM, C_LDR_PRE_REG,
      C_LDR_POST_IMM, C_LDR_POST_REG,
      C_LDRH_OFF, C_LDRH_PRE,
      C_LDRH_POST: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] c);
    case (c)
      C_STR_OFF_IMM, C_STR_OFF_REG,
      C_STR_PRE_IMM, C_STR_PRE_REG,
      C_STR_POST_IMM, C_STR_POST_REG,
      C_STRH_OFF, C_STRH_PRE,
      C_STRH_POST: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  // Pre/post-indexed forms need a base-register writeback cycle.
  function automatic logic is_indexed(input logic [5:0] c);
    case (c)
      C_STR_PRE_IMM, C_STR_PRE_REG,
      C_STR_POST_IMM, C_STR_POST_REG,
      C_LDR_PRE_IMM, C_LDR_PRE_REG,
      C_LDR_POST_IMM, C_LDR_POST_REG,
      C_STRH_PRE, C_STRH_POST,
      C_LDRH_PRE, C_LDRH_POST: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_valid(input logic [5:0] c);
    return is_dp(c) || is_branch(c) ||
           is_load(c) || is_store(c);
  endfunction

endpackage

// File: rtl/arm_moc_timer.sv
// Wait-cycle counter for the memory handshake; saturating.
// Ports: clk, reset, clr (zero), en (count), timeout (cnt==TIMEOUT-1).
module arm_moc_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/arm_control_sequencer.sv
// Microprogram sequencer: fetch/decode/execute/memory-wait walk.
// Ports: clk, reset, enc_state, cond_pass, moc -> state, mfa, mem_rw, abort, undef.
module arm_control_sequencer
  import arm_ctrl_pkg::*;
#(
  parameter int MOC_TIMEOUT = 15,
  parameter int STATE_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               cond_pass,
  input  logic               moc,
  output logic [STATE_W-1:0] state,
  output logic               mfa,
  output logic               mem_rw,
  output logic               abort,
  output logic               undef
);

  logic [STATE_W-1:0] nxt;
  logic               wb_flag;
  logic               in_wait;
  logic               timeout;

  assign in_wait = (state == S_FETCH_READ) ||
                   (state == S_LOAD_WAIT)  ||
                   (state == S_STORE_WAIT);

  // Counter sits at zero outside wait states, so entry starts at 0.
  arm_moc_timer #(
    .TIMEOUT (MOC_TIMEOUT),
    .CNT_W   (STATE_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_wait),
    .en      (in_wait),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RESET;
      wb_flag <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_DECODE)
        wb_flag <= is_indexed(enc_state);
    end
  end

  always_comb begin
    nxt    = S_FETCH_ADDR;
    mfa    = 1'b0;
    mem_rw = 1'b1;
    abort  = 1'b0;
    undef  = 1'b0;
    unique case (1'b1)
      (state == S_RESET): nxt = S_FETCH_ADDR;
      (state == S_FETCH_ADDR): nxt = S_FETCH_READ;
      (state == S_FETCH_READ): begin
        mfa = 1'b1;
        if (moc)
          nxt = S_FETCH_INC;
        else if (timeout)
          nxt = S_ABORT;
        else
          nxt = S_FETCH_READ;
      end
      (state == S_FETCH_INC): nxt = S_DECODE;
      (state == S_DECODE): begin
        if (!cond_pass || (enc_state == '0))
          nxt = S_FETCH_ADDR;
        else if (is_valid(enc_state))
          nxt = enc_state;
        else
          nxt = S_UNDEF;
      end
      (state == S_LOAD_WAIT),
      (state == S_STORE_WAIT): begin
        mfa    = 1'b1;
        mem_rw = (state == S_LOAD_WAIT);
        if (moc)
          nxt = wb_flag ? S_WRITEBACK : S_FETCH_ADDR;
        else if (timeout)
          nxt = S_ABORT;
        else
          nxt = state;
      end
      (state == S_ABORT): abort = 1'b1;
      (state == S_UNDEF): undef = 1'b1;
      is_load(state):  nxt = S_LOAD_WAIT;
      is_store(state): nxt = S_STORE_WAIT;
      default: nxt = S_FETCH_ADDR;
    endcase
  end

endmodule

// File: tb/tb_arm_control_sequencer.sv
// Directed bench for arm_control_sequencer.
// Tasks per scenario; each checks its own expected micro-state trace.
module tb_arm_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] enc_state;
  logic       cond_pass;
  logic       moc;
  logic [5:0] state;
  logic       mfa;
  logic       mem_rw;
  logic       abort;
  logic       undef;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  arm_control_sequencer #(
    .MOC_TIMEOUT (15),
    .STATE_W     (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enc_state (enc_state),
    .cond_pass (cond_pass),
    .moc       (moc),
    .state     (state),
    .mfa       (mfa),
    .mem_rw    (mem_rw),
    .abort     (abort),
    .undef     (undef)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From state 1 with moc high: 1 -> 2 -> 3 -> 4.
  task automatic go_decode();
    moc = 1'b1;
    step();
    step();
    step();
    checks++;
    if (state !== 6'd4)
      $display("FAIL go_decode state=%0d exp=4", state);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1; moc = 1'b1;
    enc_state = 6'd0; cond_pass = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state !== 6'd0 || mfa !== 1'b0 || mem_rw !== 1'b1 ||
          abort !== 1'b0 || undef !== 1'b0)
        $display("FAIL reset st=%0d mfa=%b rw=%b ab=%b ud=%b exp 0/0/1/0/0",
                 state, mfa, mem_rw, abort, undef);
      else passes++;
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (state !== 6'(i) || mfa !== (i == 2))
        $display("FAIL fetch st=%0d mfa=%b exp st=%0d mfa=%b",
                 state, mfa, i, (i == 2));
      else passes++;
    end
    step();
    checks++;
    if (state !== 6'd1)
      $display("FAIL enc0 state=%0d exp=1", state);
    else passes++;
  endtask

  task automatic test_dp();
    go_decode();
    enc_state = 6'd6; cond_pass = 1'b1;
    step();
    enc_state = 6'd0; cond_pass = 1'b0;
    checks++;
    if (state !== 6'd6)
      $display("FAIL dp_exec state=%0d exp=6", state);
    else passes++;
    step();
    checks++;
    if (state !== 6'd1)
      $display("FAIL dp_ret state=%0d exp=1", state);
    else passes++;
    go_decode();
    enc_state = 6'd6; cond_pass = 1'b0;
    step();
    enc_state = 6'd0;
    checks++;
    if (state !== 6'd1)
      $display("FAIL dp_condfail state=%0d exp=1", state);
    else passes++;
  endtask

  task automatic test_indexed_load();
    go_decode();
    enc_state = 6'd22; cond_pass = 1'b1; moc = 1'b0;
    step();
    enc_state = 6'd0; cond_pass = 1'b0;
    checks++;
    if (state !== 6'd22 || mem_rw !== 1'b1)
      $display("FAIL ldi_entry state=%0d rw=%b exp 22/1", state, mem_rw);
    else passes++;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 6'd48 || mfa !== 1'b1 || mem_rw !== 1'b1)
        $display("FAIL ldi_wait%0d st=%0d mfa=%b rw=%b exp 48/1/1",
                 i, state, mfa, mem_rw);
      else passes++;
      if (i == 3) moc = 1'b1;
      step();
    end
    checks++;
    if (state !== 6'd50 || mem_rw !== 1'b1)
      $display("FAIL ldi_wb state=%0d rw=%b exp 50/1", state, mem_rw);
    else passes++;
    step();
    checks++;
    if (state !== 6'd1)
      $display("FAIL ldi_ret state=%0d exp=1", state);
    else passes++;
  endtask

  task automatic test_offset_store();
    go_decode();
    enc_state = 6'd12; cond_pass = 1'b1;
    step();
    enc_state = 6'd0; cond_pass = 1'b0;
    checks++;
    if (state !== 6'd12)
      $display("FAIL sto_entry state=%0d exp=12", state);
    else passes++;
    step();
    checks++;
    if (state !== 6'd49 || mem_rw !== 1'b0 || mfa !== 1'b1)
      $display("FAIL sto_wait st=%0d rw=%b mfa=%b exp 49/0/1",
               state, mem_rw, mfa);
    else passes++;
    step();
    checks++;
    if (state !== 6'd1)
      $display("FAIL sto_ret state=%0d exp=1", state);
    else passes++;
  endtask

  task automatic test_back_to_back();
    go_decode();
    enc_state = 6'd20; cond_pass = 1'b1;
    step();
    enc_state = 6'd0; cond_pass = 1'b0;
    step();
    checks++;
    if (state !== 6'd48)
      $display("FAIL ldo_wait state=%0d exp=48", state);
    else passes++;
    step();
    checks++;
    if (state !== 6'd1)
      $display("FAIL ldo_ret state=%0d exp=1", state);
    else passes++;
  endtask

  task automatic test_timeout();
    moc = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (state !== 6'd2 || abort !== 1'b0)
        $display("FAIL to_wait%0d st=%0d ab=%b exp 2/0", i, state, abort);
      else passes++;
      step();
    end
    checks++;
    if (state !== 6'd62 || abort !== 1'b1 || mfa !== 1'b0)
      $display("FAIL to_abort st=%0d ab=%b mfa=%b exp 62/1/0",
               state, abort, mfa);
    else passes++;
    step();
    checks++;
    if (state !== 6'd1 || abort !== 1'b0)
      $display("FAIL to_ret st=%0d ab=%b exp 1/0", state, abort);
    else passes++;
  endtask

  task automatic test_timeout_edge();
    moc = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (state !== 6'd2)
        $display("FAIL toe_wait%0d state=%0d exp=2", i, state);
      else passes++;
      if (i == 14) moc = 1'b1;
      step();
    end
    checks++;
    if (state !== 6'd3 || abort !== 1'b0)
      $display("FAIL toe_late st=%0d ab=%b exp 3/0", state, abort);
    else passes++;
    step();
    step();
    checks++;
    if (state !== 6'd1)
      $display("FAIL toe_ret state=%0d exp=1", state);
    else passes++;
  endtask

  task automatic test_undef();
    go_decode();
    enc_state = 6'd9; cond_pass = 1'b1;
    step();
    enc_state = 6'd0; cond_pass = 1'b0;
    checks++;
    if (state !== 6'd63 || undef !== 1'b1)
      $display("FAIL undef st=%0d ud=%b exp 63/1", state, undef);
    else passes++;
    step();
    checks++;
    if (state !== 6'd1 || undef !== 1'b0)
      $display("FAIL undef_ret st=%0d ud=%b exp 1/0", state, undef);
    else passes++;
  endtask

  task automatic test_reset_midwait();
    go_decode();
    enc_state = 6'd22; cond_pass = 1'b1; moc = 1'b0;
    step();
    enc_state = 6'd0; cond_pass = 1'b0;
    step();
    checks++;
    if (state !== 6'd48 || dut.wb_flag !== 1'b1)
      $display("FAIL rmw_pre st=%0d wb=%b exp 48/1", state, dut.wb_flag);
    else passes++;
    reset = 1'b1;
    step();
    checks++;
    if (state !== 6'd0 || mfa !== 1'b0 || dut.wb_flag !== 1'b0)
      $display("FAIL rmw_rst st=%0d mfa=%b wb=%b exp 0/0/0",
               state, mfa, dut.wb_flag);
    else passes++;
    reset = 1'b0;
    step();
    checks++;
    if (state !== 6'd1)
      $display("FAIL rmw_ret state=%0d exp=1", state);
    else passes++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dp();
    test_indexed_load();
    test_offset_store();
    test_back_to_back();
    test_timeout();
    test_timeout_edge();
    test_undef();
    test_reset_midwait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
